// File: rtl/mem_data_resp.sv
// mem_data_resp: data-memory responder for the core's load/store port.
// Serves one read or byte-enabled write at a time from an internal word array,
// inserting WAIT_CYCLES wait states and answering with a one-cycle ready pulse.
module mem_data_resp #(
    parameter int unsigned B_WIDTH     = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [B_WIDTH-1:0]   mem_addr,
    input  logic [B_WIDTH-1:0]   mem_wdata,
    input  logic [B_WIDTH/8-1:0] write_byte_en,
    input  logic                 mem_read_en,
    input  logic                 mem_write_en,
    output logic [B_WIDTH-1:0]   mem_rdata,
    output logic                 mem_ready,
    output logic                 mem_err
);

    localparam int unsigned NB   = B_WIDTH / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [B_WIDTH-1:0] DEPTH_L = B_WIDTH'(DEPTH_WORDS);
    localparam logic [3:0]         WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [AW-1:0]      r_idx;
    logic [B_WIDTH-1:0] r_wdata;
    logic [NB-1:0]      r_be;
    logic               r_is_write;
    logic               r_err;
    logic [B_WIDTH-1:0] r_rdata;
    logic               r_ready;
    logic               r_resp_err;

    // Word array; deliberately not reset
    logic [B_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [B_WIDTH-1:0] w_word;
    logic               w_req;
    logic               w_err;

    // Request decode: word index and illegal-request detection at capture time
    assign w_word = mem_addr >> OFFW;
    assign w_req  = mem_read_en | mem_write_en;
    assign w_err  = (mem_read_en & mem_write_en) | (w_word >= DEPTH_L);

    // Request FSM with registered read data, ready and error outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_resp_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx      <= AW'(w_word);
                        r_wdata    <= mem_wdata;
                        r_be       <= write_byte_en;
                        r_is_write <= mem_write_en;
                        r_err      <= w_err;
                        r_cnt      <= WAIT_L;
                        if (WAIT_L != 4'd0) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!r_err && !r_is_write) begin
                        r_rdata <= r_mem[r_idx];
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_ready    <= 1'b1;
                    r_resp_err <= r_err;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Lane-masked write commit on the edge leaving ACCESS
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && r_is_write && !r_err) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_ready = r_ready;
    assign mem_err   = r_resp_err;

endmodule

// File: tb/tb_mem_data_resp.sv
// tb_mem_data_resp: scoreboard bench for mem_data_resp with a behavioural memory model.
module tb_mem_data_resp;

    localparam int unsigned W     = 1;
    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  write_byte_en;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    mem_data_resp #(
        .B_WIDTH    (32),
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .write_byte_en(write_byte_en),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_err      (mem_err)
    );

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int];
    logic [31:0] last_rdata;
    int          cyc;
    int          checks;
    int          failures;
    logic [31:0] pool [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to check response latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: what the responder must answer for a request captured at edge cap
    task automatic model_push(input bit re, input bit we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be, input int cap);
        exp_t        e;
        logic [31:0] idx;
        logic [31:0] word;
        idx   = a / 4;
        e.err = (re && we) || (idx >= DEPTH);
        if (!e.err && we) begin
            word = model_mem.exists(int'(idx)) ? model_mem[int'(idx)] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (be[i]) word[8*i +: 8] = d[8*i +: 8];
            model_mem[int'(idx)] = word;
        end
        if (!e.err && re) last_rdata = model_mem[int'(idx)];
        e.rdata = last_rdata;
        e.cyc   = cap + int'(W) + 2;
        exp_q.push_back(e);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (mem_ready) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ready actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = exp_q.pop_front();
                if (mem_err !== e.err) begin
                    failures++;
                    $display("FAIL resp_err actual=%0b required=%0b cyc=%0d", mem_err, e.err, cyc);
                end
                checks++;
                if (mem_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL resp_rdata actual=%h required=%h cyc=%0d", mem_rdata, e.rdata, cyc);
                end
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL resp_latency actual=%0d required=%0d", cyc, e.cyc);
                end
            end
        end
    end

    // Issue one request, wait (bounded) for its ready, drop enables in the ready cycle
    task automatic req(input bit re, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        bit seen;
        @(posedge clk); #1;
        mem_read_en   = re;
        mem_write_en  = we;
        mem_addr      = a;
        mem_wdata     = d;
        write_byte_en = be;
        model_push(re, we, a, d, be, cyc + 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1 addr=%h", a);
        end
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        int   c;
        logic [31:0] a;
        logic [31:0] prior20;
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        last_rdata    = 32'h0;
        rst           = 1'b1;
        mem_addr      = 32'h0;
        mem_wdata     = 32'h0;
        write_byte_en = 4'h0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(mem_ready), 32'h0);
        chk("reset_err", 32'(mem_err), 32'h0);
        chk("reset_rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        idle(2);

        // Full write then read back
        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        // Partial write and zero-lane write
        req(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        req(1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'h0);
        req(1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
        // Errors: out-of-range read, both enables high
        req(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0);
        req(1'b1, 1'b1, 32'h10, 32'h55555555, 4'hF);
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        req(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1, 4'hF);
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);

        // Held read across two transactions
        @(posedge clk); #1;
        mem_read_en = 1'b1;
        mem_addr    = 32'h10;
        c = cyc;
        model_push(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, c + 1);
        model_push(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, c + 1 + int'(W) + 3);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_ready) n++;
            if (n == 2) break;
        end
        mem_read_en = 1'b0;
        chk("held_pulses", 32'(n), 32'd2);
        idle(8);

        // Mid-cycle reset while a nonzero read response is on the outputs
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("midcycle_rst_ready", 32'(mem_ready), 32'h0);
        chk("midcycle_rst_err", 32'(mem_err), 32'h0);
        chk("midcycle_rst_rdata", mem_rdata, 32'h0);
        last_rdata = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Reset during WAIT of a write drops the write
        req(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        prior20 = model_mem[8];
        @(posedge clk); #1;
        mem_write_en  = 1'b1;
        mem_addr      = 32'h20;
        mem_wdata     = 32'hCAFEF00D;
        write_byte_en = 4'hF;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("wait_rst_ready", 32'(mem_ready), 32'h0);
        mem_write_en = 1'b0;
        last_rdata   = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(8);
        req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("rst_write_dropped", model_mem[8], prior20);

        // Randomized traffic over a small pool of words
        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'((i * 131 + 7) % DEPTH) * 4;
            req(1'b0, 1'b1, pool[i], $urandom, 4'hF);
        end
        for (int i = 0; i < 60; i++) begin
            int k;
            k = int'($urandom_range(99, 0));
            a = pool[$urandom_range(7, 0)] | 32'($urandom_range(3, 0));
            if (k < 45)      req(1'b1, 1'b0, a, 32'h0, 4'h0);
            else if (k < 85) req(1'b0, 1'b1, a, $urandom, 4'($urandom_range(15, 0)));
            else if (k < 92) req(1'b1, 1'b1, a, $urandom, 4'hF);
            else             req(k[0], ~k[0], $urandom_range(32'hFFFF_FFFF, 32'(4 * DEPTH)),
                                 $urandom, 4'hF);
        end

        // Drain and confirm nothing outstanding
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
